// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instr_fetch_pkg;

    localparam logic [1:0] S_VEC      = 2'd0;
    localparam logic [1:0] S_VEC_WAIT = 2'd1;
    localparam logic [1:0] S_RUN      = 2'd2;

    localparam logic [15:0] RESET_VECTOR_DEF = 16'hFFFE;
    localparam logic [15:0] PC_INC           = 16'd2;

    typedef struct packed {
        logic [15:0] data;
        logic [15:0] addr;
    } fetch_word_t;

    function automatic logic [15:0] word_align(input logic [15:0] a);
        return a & 16'hFFFE;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous {data, addr} FIFO with flush, simultaneous push/pop and occupancy count.
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  fetch_word_t       i_wdata,
    input  logic              i_pop,
    output fetch_word_t       o_head,
    output logic              o_valid,
    output logic [CW-1:0]     o_count
);

    fetch_word_t       r_mem [DEPTH];
    fetch_word_t       r_hold;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_valid = (r_count != '0);
    assign w_push  = i_push & ~i_flush;
    assign w_pop   = i_pop & w_valid & ~i_flush;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    // Tracks the last presented head so the outputs hold steady once empty.
    always_ff @(posedge clk) begin
        if (rst)          r_hold <= '0;
        else if (w_valid) r_hold <= r_mem[r_rd_ptr];
    end

    assign o_valid = w_valid;
    assign o_head  = w_valid ? r_mem[r_rd_ptr] : r_hold;
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reset-vector load, credit-based ROM issue, FIFO to decoder, redirect/flush.
//   state      | meaning
//   S_VEC      | read ROM at RESET_VECTOR
//   S_VEC_WAIT | capture vector word into fetch PC
//   S_RUN      | stream words, honour redirects
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int          DEPTH        = 2,
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] MDB_out,
    output logic [15:0] MAB,
    output logic        mem_rd,
    input  logic        pc_load,
    input  logic [15:0] pc_new,
    output logic [15:0] instr,
    output logic [15:0] instr_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] fetch_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]     r_state;
    logic [15:0]    r_fetch_pc;
    logic [15:0]    r_issue_addr;
    logic           r_inflight;

    logic           w_run;
    logic           w_redirect;
    logic           w_issue;
    logic           w_push;
    logic           w_pop;
    logic           w_valid;
    logic [CW-1:0]  w_count;
    logic [CW:0]    w_credit;
    fetch_word_t    w_head;
    fetch_word_t    w_wdata;

    assign w_run      = (r_state == S_RUN);
    assign w_redirect = w_run & pc_load;
    assign w_pop      = w_valid & instr_ready;

    // A word popped this cycle frees its slot for this cycle's issue, which is what sustains 1 word/cycle.
    assign w_credit = {1'b0, w_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
    assign w_issue  = w_run & ~pc_load & ~rst & (w_credit < (CW + 1)'(DEPTH));
    assign w_push   = w_run & r_inflight & ~pc_load;
    assign w_wdata  = '{data: MDB_out, addr: r_issue_addr};

    assign mem_rd = ~rst & ((r_state == S_VEC) | w_issue);
    assign MAB    = w_run ? r_fetch_pc : RESET_VECTOR;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_VEC;
            r_fetch_pc   <= '0;
            r_issue_addr <= '0;
            r_inflight   <= 1'b0;
        end else begin
            case (r_state)
                S_VEC: begin
                    r_state    <= S_VEC_WAIT;
                    r_inflight <= 1'b0;
                end
                S_VEC_WAIT: begin
                    r_fetch_pc <= word_align(MDB_out);
                    r_state    <= S_RUN;
                end
                S_RUN: begin
                    r_inflight <= w_issue;
                    if (pc_load) begin
                        r_fetch_pc <= word_align(pc_new);
                    end else if (w_issue) begin
                        r_fetch_pc   <= r_fetch_pc + PC_INC;
                        r_issue_addr <= r_fetch_pc;
                    end
                end
                default: begin
                    r_state    <= S_VEC;
                    r_inflight <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_redirect),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign instr       = w_head.data;
    assign instr_addr  = w_head.addr;
    assign instr_valid = w_valid;
    assign fetch_pc    = r_fetch_pc;

endmodule
